// File: rtl/atm_pkg.sv
// Shared definitions for the ATM PIN checker: state encoding, BCD width,
// default geometry and the account PIN digit formula.
package atm_pkg;

    localparam int BCD_W             = 4;
    localparam int DEFAULT_DIGITS    = 4;
    localparam int DEFAULT_ID_WIDTH  = 3;
    localparam int DEFAULT_MAX_TRIES = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        LOCKED  = 2'd3
    } state_e;

    // Digit idx (0 = first keyed) of the PIN stored for an account.
    function automatic logic [BCD_W-1:0] pin_digit(input int unsigned account,
                                                   input int unsigned idx);
        return BCD_W'((account + 32'd1 + idx) % 32'd10);
    endfunction

endpackage

// File: rtl/atm_pin_rom.sv
// Combinational PIN table: the first keyed digit sits in the most significant
// nibble so the result lines up with the checker's shift-in buffer.
module atm_pin_rom
    import atm_pkg::*;
#(
    parameter int DIGITS   = DEFAULT_DIGITS,
    parameter int ID_WIDTH = DEFAULT_ID_WIDTH
) (
    input  logic [ID_WIDTH-1:0]     id_i,
    output logic [DIGITS*BCD_W-1:0] pin_o
);

    // NOTE: every bit is given a default before the loop, so no latch can be inferred.
    always_comb begin
        pin_o = '0;
        for (int i = 0; i < DIGITS; i++) begin
            pin_o[(DIGITS-1-i)*BCD_W +: BCD_W] = pin_digit(32'(id_i), i);
        end
    end

endmodule

// File: rtl/atm_pin_checker.sv
// Keypad PIN collector/verifier feeding the ATM control FSM with verdict pulses.
// Define ATM_PIN_LOCKOUT_EN to add the per-session fail counter and LOCKED state.
module atm_pin_checker
    import atm_pkg::*;
#(
    parameter int DIGITS    = DEFAULT_DIGITS,
    parameter int ID_WIDTH  = DEFAULT_ID_WIDTH,
    parameter int MAX_TRIES = DEFAULT_MAX_TRIES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                card_valid,
    input  logic [ID_WIDTH-1:0] card_id,
    input  logic                key_valid,
    input  logic [BCD_W-1:0]    key_digit,
    input  logic                key_clear,
    input  logic                key_enter,
    input  logic                abort,
    output logic                pin_ok,
    output logic                wrong_psw,
    output logic                locked,
    output logic                busy,
    output logic [2:0]          digit_count
);

    localparam int         PIN_W    = DIGITS * BCD_W;
    localparam logic [2:0] CNT_FULL = 3'(DIGITS);

    state_e              state_q, state_d;
    logic                card_q;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [PIN_W-1:0]    buf_q, buf_d;
    logic [2:0]          count_q, count_d;
    logic                pin_ok_q, pin_ok_d;
    logic                wrong_q, wrong_d;
    logic [PIN_W-1:0]    rom_pin;

    logic card_rise;
    logic end_session;
    logic digit_ok;

`ifdef ATM_PIN_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);
    logic [FAIL_W-1:0] fail_q, fail_d;
`else
    localparam int unused_max_tries = MAX_TRIES;
`endif

    atm_pin_rom #(
        .DIGITS   (DIGITS),
        .ID_WIDTH (ID_WIDTH)
    ) u_rom (
        .id_i  (id_q),
        .pin_o (rom_pin)
    );

    assign card_rise   = card_valid && !card_q;
    assign end_session = (state_q != IDLE) && (abort || !card_valid);
    assign digit_ok    = key_valid && (key_digit <= 4'd9);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        buf_d    = buf_q;
        count_d  = count_q;
        pin_ok_d = 1'b0;
        wrong_d  = 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
        fail_d   = fail_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (card_rise && !abort) begin
                    state_d = COLLECT;
                    id_d    = card_id;
                    buf_d   = '0;
                    count_d = '0;
`ifdef ATM_PIN_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end
            end
            COLLECT: begin
                if (key_clear) begin
                    buf_d   = '0;
                    count_d = '0;
                end else if (key_enter) begin
                    if (count_q == CNT_FULL) begin
                        state_d = CHECK;
                    end else begin
                        wrong_d = 1'b1;
                        buf_d   = '0;
                        count_d = '0;
                    end
                end else if (digit_ok && count_q != CNT_FULL) begin
                    buf_d   = {buf_q[PIN_W-BCD_W-1:0], key_digit};
                    count_d = count_q + 3'd1;
                end
            end
            CHECK: begin
                state_d = COLLECT;
                buf_d   = '0;
                count_d = '0;
                if (buf_q == rom_pin) begin
                    pin_ok_d = 1'b1;
`ifdef ATM_PIN_LOCKOUT_EN
                    fail_d   = '0;
`endif
                end else begin
                    wrong_d = 1'b1;
                end
            end
            LOCKED: ;
            default: state_d = IDLE;
        endcase

`ifdef ATM_PIN_LOCKOUT_EN
        // Both failure paths (short entry, bad compare) meet here.
        if (wrong_d) begin
            fail_d = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;
            if (fail_d == FAIL_MAX) state_d = LOCKED;
        end
`endif

        if (end_session) begin
            state_d  = IDLE;
            buf_d    = '0;
            count_d  = '0;
            pin_ok_d = 1'b0;
            wrong_d  = 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
            fail_d   = '0;
`endif
        end
    end

    // NOTE: the PIN buffer is a plain register, not a RAM, so it takes a reset value.
    // card_q resets high so a card held through reset needs a fresh insertion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            card_q   <= 1'b1;
            id_q     <= '0;
            buf_q    <= '0;
            count_q  <= '0;
            pin_ok_q <= 1'b0;
            wrong_q  <= 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
            fail_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q  <= state_d;
            card_q   <= card_valid;
            id_q     <= id_d;
            buf_q    <= buf_d;
            count_q  <= count_d;
            pin_ok_q <= pin_ok_d;
            wrong_q  <= wrong_d;
`ifdef ATM_PIN_LOCKOUT_EN
            fail_q   <= fail_d;
`endif
        end
    end

    assign pin_ok      = pin_ok_q;
    assign wrong_psw   = wrong_q;
    assign busy        = (state_q != IDLE);
    assign digit_count = count_q;
`ifdef ATM_PIN_LOCKOUT_EN
    assign locked      = (state_q == LOCKED);
`else
    assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_atm_pin_checker.sv
// Directed scoreboard bench for atm_pin_checker: stimulus queues expected
// verdict pulses with their cycle, a negedge monitor pops and compares them.
module tb_atm_pin_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       card_valid;
    logic [2:0] card_id;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       key_clear;
    logic       key_enter;
    logic       abort;
    logic       pin_ok;
    logic       wrong_psw;
    logic       locked;
    logic       busy;
    logic [2:0] digit_count;

    typedef struct {
        bit is_ok;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    atm_pin_checker dut (
        .clk         (clk),
        .rst         (rst),
        .card_valid  (card_valid),
        .card_id     (card_id),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .key_clear   (key_clear),
        .key_enter   (key_enter),
        .abort       (abort),
        .pin_ok      (pin_ok),
        .wrong_psw   (wrong_psw),
        .locked      (locked),
        .busy        (busy),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every verdict pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (pin_ok === 1'b1 || wrong_psw === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: pin_ok=%0b wrong_psw=%0b at cycle %0d, expected no pulse",
                         pin_ok, wrong_psw, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {30'd0, pin_ok, wrong_psw}, e.is_ok ? 32'd2 : 32'd1);
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic press_pin(input logic [15:0] p);
        for (int i = 0; i < 4; i++) press(p[15-4*i -: 4]);
    endtask

    // Enter driven in cycle N; a pulse, if any, is due at N + lat.
    task automatic enter(input bit expect_pulse, input bit is_ok, input int lat);
        if (expect_pulse) exp_q.push_back('{is_ok, cyc + lat});
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic insert(input logic [2:0] id);
        card_id    = id;
        card_valid = 1'b1;
        tick();
        check("busy_after_insert", busy, 1);
        check("count_after_insert", digit_count, 0);
    endtask

    task automatic remove();
        card_valid = 1'b0;
        tick();
        check("busy_after_remove", busy, 0);
        check("locked_after_remove", locked, 0);
    endtask

    initial begin
        rst        = 1'b0;
        card_valid = 1'b0;
        card_id    = '0;
        key_valid  = 1'b0;
        key_digit  = '0;
        key_clear  = 1'b0;
        key_enter  = 1'b0;
        abort      = 1'b0;
        tick(2);
        check("rst_pin_ok", pin_ok, 0);
        check("rst_wrong_psw", wrong_psw, 0);
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 0);
        check("rst_count", digit_count, 0);
        rst = 1'b1;
        tick();

        // Account 0 = 1234: correct entry.
        insert(3'd0);
        press_pin(16'h1234);
        check("count_full", digit_count, 4);
        enter(1, 1, 2);
        check("busy_in_check", busy, 1);
        tick();
        check("count_cleared_on_pulse", digit_count, 0);
        remove();

        // Account 7 = 8901: wrong then right; fail count must restart.
        insert(3'd7);
        press_pin(16'h8902);
        enter(1, 0, 2);
        tick();
        press_pin(16'h8901);
        enter(1, 1, 2);
        tick();
        press_pin(16'h0000);
        enter(1, 0, 2);
        tick();
        press_pin(16'h1111);
        enter(1, 0, 2);
        tick();
        check("not_locked_after_clear", locked, 0);
        remove();

        // Short entry fails in one cycle; a fifth digit is dropped.
        insert(3'd0);
        press(4'd1);
        press(4'd2);
        enter(1, 0, 1);
        check("count_after_short", digit_count, 0);
        press_pin(16'h1234);
        press(4'd5);
        check("count_saturated", digit_count, 4);
        enter(1, 1, 2);
        tick();
        remove();

        // Account 3 = 4567: three failures.
        insert(3'd3);
        for (int t = 0; t < 3; t++) begin
            press_pin(16'h0000);
            enter(1, 0, 2);
            tick();
        end
`ifdef ATM_PIN_LOCKOUT_EN
        check("locked_after_three", locked, 1);
        check("busy_when_locked", busy, 1);
        press_pin(16'h4567);
        enter(0, 0, 0);
        tick(2);
        check("count_when_locked", digit_count, 0);
        check("still_locked", locked, 1);
`else
        check("never_locked", locked, 0);
        press_pin(16'h4567);
        enter(1, 1, 2);
        tick();
`endif
        remove();

        // Account 1 = 2345: clear beats enter; invalid digits ignored.
        insert(3'd1);
        press_pin(16'h2345);
        key_clear = 1'b1;
        key_enter = 1'b1;
        tick();
        key_clear = 1'b0;
        key_enter = 1'b0;
        check("count_after_clear", digit_count, 0);
        tick(2);
        press(4'd12);
        check("count_after_bad_digit", digit_count, 0);
        press(4'd2);
        press(4'd10);
        press(4'd3);
        press(4'd4);
        press(4'd5);
        check("count_with_bad_mixed", digit_count, 4);
        enter(1, 1, 2);
        tick();
        remove();

        // Account 2 = 3456: abort during CHECK suppresses the verdict.
        insert(3'd2);
        press_pin(16'h3456);
        enter(0, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_after_abort", busy, 0);
        tick(2);
        check("no_restart_without_edge", busy, 0);
        remove();

        // Reset mid-collect; a held card must be reinserted.
        insert(3'd0);
        press(4'd1);
        press(4'd2);
        rst = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_count", digit_count, 0);
        check("midrst_locked", locked, 0);
        rst = 1'b1;
        tick(2);
        check("held_card_no_session", busy, 0);
        remove();

        tick(4);
        check("pending_pulses", exp_q.size(), 0);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("FAIL missing_pulse: pin_ok=%0b expected at cycle %0d, got none", e.is_ok, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atm_pin_checker.md
Name: atm_pin_checker

Overview:
- Upstream stage of the ATM control FSM.
- Collects BCD keypad digits for the inserted card, compares them against the account's stored PIN, and emits one-cycle verdict pulses.
- wrong_psw drives the control FSM's wrong_psw input. pin_ok tells the FSM the PIN passed.
- Tracks consecutive failures per card session and locks the keypad after MAX_TRIES failures.

Parameters:
- DIGITS, 4, PIN length in BCD digits.
- ID_WIDTH, 3, account id width (2**ID_WIDTH accounts).
- MAX_TRIES, 3, consecutive failures before lock (lockout build only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- card_valid  in  1  card present. Rising edge starts a session and latches card_id.
- card_id  in  ID_WIDTH  account id of the inserted card.
- key_valid  in  1  one-cycle strobe: key_digit valid.
- key_digit  in  4  BCD digit 0-9. Values 10-15 are ignored.
- key_clear  in  1  one-cycle strobe: discard the digits entered so far.
- key_enter  in  1  one-cycle strobe: submit the entry.
- abort  in  1  timeout or card ejection from the control FSM. Ends the session.
- pin_ok  out  1  one-cycle pulse: PIN matched.
- wrong_psw  out  1  one-cycle pulse: PIN mismatched or entry too short.
- locked  out  1  level: keypad locked for this session.
- busy  out  1  level: a session is active (state != IDLE).
- digit_count  out  3  number of digits currently buffered (0..DIGITS).

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-low; all flops are updated only on the rising edge of clk.
- Reset values: pin_ok=0, wrong_psw=0, locked=0, busy=0, digit_count=0, state=IDLE, digit buffer=0, fail count=0, latched id=0.
- States:
  - IDLE: waits for a rising edge of card_valid. On that edge, latch card_id, clear the buffer and fail count, go to COLLECT.
  - COLLECT: each accepted key_valid with digit ≤9 shifts the digit into the buffer and increments digit_count. Once digit_count=DIGITS, further digits are dropped.
  - CHECK: one cycle. Compares the buffer against the ROM PIN of the latched id. Goes to COLLECT, or to LOCKED when the lockout threshold is reached.
  - LOCKED: locked=1. All keys ignored. Leaves only via abort or card_valid=0.
- COLLECT priorities, same cycle: key_clear > key_enter > key_valid.
  - clear: digit_count←0, any simultaneous enter or digit is dropped.
  - enter with digit_count<DIGITS: wrong_psw pulse next cycle, counts as a failure, buffer cleared, no CHECK.
  - enter with digit_count=DIGITS: go to CHECK.
- Latency: key_enter in cycle N, CHECK in N+1, pin_ok or wrong_psw high in N+2 for exactly one cycle. The buffer clears in the same cycle as the pulse.
- Fail count:
  - Saturating, clears on pin_ok.
  - When a failure makes the count reach MAX_TRIES, wrong_psw is still pulsed and the state goes to LOCKED.
- Session end:
  - abort, or card_valid falling, in any state: next state IDLE, buffer, count and locked cleared.
  - Any pulse scheduled for the next cycle is suppressed.
  - abort has priority over every key strobe.
- PIN ROM:
  - Account n, digit i (i=0 is the first entered digit) = (n+1+i) mod 10.
  - Examples: account 0 = 1234, account 7 = 8901.
- busy=1 in COLLECT, CHECK and LOCKED.
- Reset mid-session returns to IDLE with no pulse. A card still inserted must be reinserted (a new rising edge) to start a session.

Optional Feature:
- Macro: ATM_PIN_LOCKOUT_EN.
- Defined: fail counter and LOCKED state are present, behaving as above.
- Undefined:
  - No fail counter and no LOCKED state. Retries are unlimited, and failures only pulse wrong_psw.
  - locked is tied 0 and MAX_TRIES is unused.
  - The downstream FSM is then the only retry limiter.

Decomposition:
- Package atm_pkg holds:
  - state encoding constants (IDLE, COLLECT, CHECK, LOCKED);
  - BCD digit width (4);
  - default DIGITS and MAX_TRIES.
- Sub-module atm_pin_rom: purely combinational; account id in, DIGITS×4-bit PIN out, using the formula above.

Test Plan:
- Card id 0, keys 1,2,3,4, enter at cycle N → pin_ok=1 at N+2 only; wrong_psw stays 0; digit_count returns to 0.
- Card id 7, keys 8,9,0,2, enter → wrong_psw pulse at N+2; then keys 8,9,0,1, enter → pin_ok; fail count cleared.
- Card id 0, keys 1,2, enter → wrong_psw pulse, no CHECK state. Keys 1,2,3,4,5 → digit_count saturates at 4 and the 5 is dropped.
- Lockout build, card id 3: three wrong entries → third wrong_psw pulse, then locked=1. Keys ignored; card_valid low → locked=0 and busy=0 next cycle.
- Same cycle key_clear + key_enter with 4 digits buffered → no pulse, digit_count=0. Key_digit 12 with key_valid → ignored.
- Abort in the CHECK cycle → no pin_ok or wrong_psw pulse, state IDLE. Rst low mid-COLLECT → all outputs at reset values on the next edge.
